imem_fetch_ctrl: RTL
====================

# imem_fetch_ctrl

Controller that owns the instruction memory and sequences instruction fetch for the 5-stage pipeline. After reset it accepts a boot-load stream that writes the program into instruction memory. It then switches to fetch mode: it drives a PC into the memory's combinational read port and registers the result into the IF/ID output. The IF/ID output supports valid/ready backpressure from decode and branch/jump redirects.

## Interface
Parameters:
- ADDR_W, 10, word-index width of instruction memory; depth = 2^ADDR_W words
- RESET_PC, 32'h0000_0000, first fetch address (byte address, word-aligned)
- BOOT_LOAD, 1, if 1 reset enters LOAD state; if 0 reset enters RUN directly

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_valid  in  1  loader word available
- load_ready  out  1  controller accepts loader word
- load_addr  in  ADDR_W  word index to write
- load_data  in  32  instruction word
- load_last  in  1  marks final loader word
- imem_we  out  1  memory write enable
- imem_waddr  out  32  memory write byte address
- imem_wdata  out  32  memory write data
- imem_addr  out  32  memory read byte address (memory uses bits [ADDR_W+1:2])
- imem_rd  in  32  memory read data, combinational from imem_addr
- redirect  in  1  branch/jump taken; flush and reload PC
- redirect_pc  in  32  redirect target; bits [1:0] ignored
- if_valid  out  1  IF/ID holds a valid instruction
- if_ready  in  1  decode accepts IF/ID this cycle
- if_pc  out  32  PC of the instruction in IF/ID
- if_instr  out  32  instruction in IF/ID
- loading  out  1  high while in LOAD state
- load_count  out  ADDR_W+1  number of words accepted since reset

## Operation
- FSM states: LOAD, RUN. Reset goes to LOAD if BOOT_LOAD=1, else to RUN. RUN exits only on reset.
- LOAD behaviour:
  - load_ready=1 and loading=1.
  - imem_we=load_valid (combinational), imem_waddr={load_addr,2'b00}, imem_wdata=load_data.
  - Each accepted word increments load_count, saturating at 2^ADDR_W.
  - load_valid&load_last moves the state to RUN on the same edge.
  - redirect and if_ready are ignored. if_valid=0. pc holds RESET_PC.
- RUN behaviour:
  - load_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, imem_addr=pc.
  - advance = !if_valid || if_ready.
  - On advance: if_instr<=imem_rd, if_pc<=pc, if_valid<=1, pc<=pc+4.
  - Without advance: IF/ID and pc hold.
- Redirect (RUN) has priority over advance:
  - pc<={redirect_pc[31:2],2'b00}, if_valid<=0.
  - if_pc and if_instr hold their stale values.
  - This applies regardless of if_ready.
- PC wrap: pc+4 is computed modulo 4*2^ADDR_W. The address after 4*(2^ADDR_W-1) is 0. Redirect targets are likewise masked to bits [ADDR_W+1:2]; upper bits become 0.
- Reset values (asynchronous): state per BOOT_LOAD, pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0, load_count=0. All combinational outputs follow from the reset state.

## Timing
- Memory read is zero-latency. Fetch latency from pc to if_valid/if_instr is 1 cycle.
- Throughput is 1 instruction/cycle while if_ready=1.
- First fetch: the edge accepting load_last enters RUN. The next edge captures RESET_PC, so if_valid=1 two edges after the load_last acceptance. With BOOT_LOAD=0, if_valid=1 after the first edge following reset release.
- Redirect bubble: the edge with redirect=1 makes if_valid=0. The next edge loads the target instruction. Total penalty is 1 cycle.
- Boundary cases:
  - redirect together with if_valid=0: redirect wins, no capture.
  - redirect on the same cycle as load_last acceptance: redirect ignored.
  - load_valid without load_last after 2^ADDR_W words: still written (address from load_addr), and load_count saturates.
- Reset asserted mid-RUN: outputs drop to reset values immediately (not on the edge). An in-flight IF/ID instruction is discarded.

## Test plan
- BOOT_LOAD=1: reset, then load words 0x002082B3, 0x00328333, 0x004303B3 at indices 0,1,2 with load_last on the third. Required: imem_we high 3 cycles, imem_waddr 0x0, 0x4, 0x8, load_count=3, loading falls after the third edge.
- After the load, with if_ready=1: if_pc=0x0, 0x4, 0x8 on consecutive cycles with matching if_instr. First if_valid occurs 2 edges after load_last.
- Backpressure: if_valid=1 at if_pc=0x4 and if_ready=0 for 3 cycles. Required: if_pc/if_instr stable, imem_addr stays 0x8. When if_ready=1, the next if_pc is 0x8.
- Redirect to 0x41 with if_ready=0. Required: next cycle if_valid=0 and imem_addr=0x40; following cycle if_valid=1 and if_pc=0x40.
- ADDR_W=4, BOOT_LOAD=0: fetch runs sequentially to pc=0x3C; the following if_pc is 0x00. Redirect to 0x104 yields if_pc 0x04.
- Assert rst asynchronously while if_valid=1 in RUN. Required: if_valid=0, loading=1 and load_count=0 before the next clock edge. The reload sequence then works as in the first scenario.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory owner: boot-loads the program, then fetches into a
// registered IF/ID slot with valid/ready backpressure and branch redirects.
module imem_fetch_ctrl #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          BOOT_LOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              imem_we,
  output logic [31:0]       imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_rd,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              loading,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic {LOAD, RUN} state_t;

  // PC lives in a 4*2^ADDR_W byte window; everything above wraps to zero.
  localparam logic [31:0]     PC_MASK = ((32'd1 << (ADDR_W + 2)) - 32'd1) & ~32'd3;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t      state;
  logic [31:0] pc;
  logic        advance;

  assign advance = !if_valid || if_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT_LOAD ? LOAD : RUN;
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= '0;
      load_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (load_valid) begin
            if (load_count != CNT_MAX) load_count <= load_count + CNT_ONE;
            if (load_last) state <= RUN;
          end
        end
        RUN: begin
          // Redirect flushes IF/ID but leaves the stale pc/instr visible.
          if (redirect) begin
            pc       <= redirect_pc & PC_MASK;
            if_valid <= 1'b0;
          end else if (advance) begin
            if_instr <= imem_rd;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= (pc + 32'd4) & PC_MASK;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign loading    = (state == LOAD);
  assign load_ready = loading;
  assign imem_we    = loading && load_valid;
  assign imem_waddr = loading ? {{(30-ADDR_W){1'b0}}, load_addr, 2'b00} : 32'd0;
  assign imem_wdata = loading ? load_data : 32'd0;
  assign imem_addr  = pc;

endmodule
